cflog_wr_sched: RTL

- Owns the single write port of the CFLog RAM and schedules all writes to it.
- Two requesters share the port:
  - the branch/log path, which appends src/dest pairs;
  - the SpecCFA commit path, which overwrites a logged span with a block ID and rewinds the log pointer.
- When the log has no room for a pair, the block sequences the flush handshake with the TCB.
- It sits between log_monitor/SpecCFA detection and the CFLog memory, and it is the only source of the log pointer.

---
 rtl/cflog_wr_sched.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/cflog_wr_sched.sv
// CFLog RAM write scheduler: arbitrates log appends and SpecCFA commits onto one write port,
// owns the log pointer and runs the TCB flush handshake. Optional: CFLOG_FLUSH_CNT_EN adds flush_cnt.
module cflog_wr_sched #(
    parameter logic [15:0] LOG_SIZE = 16'h0080,
    parameter logic [15:0] LOG_BASE = 16'h0000
) (
    input  logic        clk,
    input  logic        puc,
    input  logic        hw_req,
    input  logic [15:0] hw_src,
    input  logic [15:0] hw_dest,
    output logic        hw_ack,
    input  logic        spec_req,
    input  logic [15:0] spec_idx,
    input  logic [15:0] spec_id,
    output logic        spec_ack,
    output logic        spec_err,
    output logic        mem_wen,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] log_ptr,
    output logic        flush,
    input  logic        flush_done,
    output logic        busy
`ifdef CFLOG_FLUSH_CNT_EN
    ,
    output logic [7:0]  flush_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SRC,
        S_WR_DEST,
        S_WR_SPEC,
        S_FLUSH_REQ,
        S_FLUSH_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] log_ptr_q, log_ptr_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dest_q, dest_d;
    logic [15:0] idx_q, idx_d;
    logic        mem_wen_q, mem_wen_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        hw_ack_q, hw_ack_d;
    logic        spec_ack_q, spec_ack_d;
    logic        spec_err_q, spec_err_d;
    logic        flush_q, flush_d;
    logic        busy_q, busy_d;
    logic        flush_exit;
    logic        no_room;

    // 17-bit compare so a pointer near 16'hFFFF cannot wrap into "room available"
    assign no_room = ({1'b0, log_ptr_q} + 17'd2) > {1'b0, LOG_SIZE};

    always_comb begin
        state_d     = state_q;
        log_ptr_d   = log_ptr_q;
        src_d       = src_q;
        dest_d      = dest_q;
        idx_d       = idx_q;
        mem_wen_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hw_ack_d    = 1'b0;
        spec_ack_d  = 1'b0;
        spec_err_d  = 1'b0;
        flush_d     = flush_q;
        flush_exit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Commits rewrite older entries, so they go ahead of a newer pair.
                if (spec_req) begin
                    idx_d = spec_idx;
                    if (spec_idx >= log_ptr_q) begin
                        spec_ack_d = 1'b1;
                        spec_err_d = 1'b1;
                    end else begin
                        state_d     = S_WR_SPEC;
                        mem_wen_d   = 1'b1;
                        mem_addr_d  = LOG_BASE + spec_idx;
                        mem_wdata_d = spec_id;
                    end
                end else if (hw_req) begin
                    src_d  = hw_src;
                    dest_d = hw_dest;
                    if (no_room) begin
                        state_d = S_FLUSH_REQ;
                        flush_d = 1'b1;
                    end else begin
                        state_d     = S_WR_SRC;
                        mem_wen_d   = 1'b1;
                        mem_addr_d  = LOG_BASE + log_ptr_q;
                        mem_wdata_d = hw_src;
                    end
                end
            end
            S_WR_SRC: begin
                state_d     = S_WR_DEST;
                mem_wen_d   = 1'b1;
                mem_addr_d  = LOG_BASE + log_ptr_q + 16'd1;
                mem_wdata_d = dest_q;
            end
            S_WR_DEST: begin
                state_d   = S_IDLE;
                log_ptr_d = log_ptr_q + 16'd2;
                hw_ack_d  = 1'b1;
            end
            S_WR_SPEC: begin
                state_d    = S_IDLE;
                log_ptr_d  = idx_q + 16'd1;
                spec_ack_d = 1'b1;
            end
            S_FLUSH_REQ: begin
                state_d = S_FLUSH_WAIT;
            end
            S_FLUSH_WAIT: begin
                // The held pair becomes entry 0 of the fresh log window.
                if (flush_done) begin
                    flush_exit  = 1'b1;
                    flush_d     = 1'b0;
                    log_ptr_d   = 16'd0;
                    state_d     = S_WR_SRC;
                    mem_wen_d   = 1'b1;
                    mem_addr_d  = LOG_BASE;
                    mem_wdata_d = src_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                flush_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge puc) begin
        if (puc) begin
            state_q     <= S_IDLE;
            log_ptr_q   <= 16'd0;
            src_q       <= 16'd0;
            dest_q      <= 16'd0;
            idx_q       <= 16'd0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 16'd0;
            hw_ack_q    <= 1'b0;
            spec_ack_q  <= 1'b0;
            spec_err_q  <= 1'b0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            log_ptr_q   <= log_ptr_d;
            src_q       <= src_d;
            dest_q      <= dest_d;
            idx_q       <= idx_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hw_ack_q    <= hw_ack_d;
            spec_ack_q  <= spec_ack_d;
            spec_err_q  <= spec_err_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
        end
    end

`ifdef CFLOG_FLUSH_CNT_EN
    logic [7:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (flush_exit && flush_cnt_q != 8'hFF) begin
            flush_cnt_d = flush_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge puc) begin
        if (puc) begin
            flush_cnt_q <= 8'd0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign flush_cnt = flush_cnt_q;
`endif

    assign hw_ack    = hw_ack_q;
    assign spec_ack  = spec_ack_q;
    assign spec_err  = spec_err_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign log_ptr   = log_ptr_q;
    assign flush     = flush_q;
    assign busy      = busy_q;

endmodule
